// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the input ports / credit return path and one output port arbiter.
interface output_port_arbiter_if #(
    parameter int unsigned NREQ = 5,
    parameter int unsigned CW   = 3
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] tail;
    logic            credit_ret;
    logic [NREQ-1:0] grant;
    logic            fire;
    logic [CW-1:0]   credits;
    logic            busy;
    logic            cr_err;

    modport master (
        output req, tail, credit_ret,
        input  grant, fire, credits, busy, cr_err
    );

    modport slave (
        input  req, tail, credit_ret,
        output grant, fire, credits, busy, cr_err
    );
endinterface

// File: rtl/output_port_arbiter.sv
// Wormhole output port arbiter: round-robin packet lock per input, credit-gated flit transfer.
module output_port_arbiter #(
    parameter int unsigned NREQ    = 5,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CW      = 3
) (
    input logic                  clk,
    input logic                  rst,
    output_port_arbiter_if.slave port
);
    localparam int unsigned   OW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [OW-1:0] PTR_RST  = OW'(NREQ - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   pick_idx;
    logic            pick_found;
    logic [CW-1:0]   credits_q, credits_d;
    logic            cr_err_q, cr_err_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            fire_c;

    // A flit moves only from the current owner and only when downstream has room.
    assign fire_c = (state_q == LOCKED) && port.req[owner_q] && (credits_q != '0);

    // Round-robin pick: first asserted request after the last packet's owner.
    always_comb begin
        int unsigned j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            j = (32'(ptr_q) + i) % NREQ;
            if (!pick_found && port.req[j]) begin
                pick_found = 1'b1;
                pick_idx   = OW'(j);
            end
        end
    end

    // Next-state, pointer, credit and registered-output logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        credits_d = credits_q;
        cr_err_d  = cr_err_q;
        grant_d   = '0;
        busy_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    owner_d = pick_idx;
                end
            end
            LOCKED: begin
                if (fire_c && port.tail[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Simultaneous consume and return cancel; a return into a full counter is an error.
        case ({fire_c, port.credit_ret})
            2'b10: credits_d = credits_q - CW'(1);
            2'b01: begin
                if (credits_q == CRED_MAX) begin
                    cr_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
            default: credits_d = credits_q;
        endcase

        if (state_d == LOCKED) begin
            grant_d = NREQ'(1) << owner_d;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= PTR_RST;
            credits_q <= CRED_MAX;
            cr_err_q  <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            cr_err_q  <= cr_err_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

    assign port.grant   = grant_q;
    assign port.fire    = fire_c;
    assign port.credits = credits_q;
    assign port.busy    = busy_q;
    assign port.cr_err  = cr_err_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: directed per-cycle vectors, monitor compares mid-cycle.
module tb_output_port_arbiter;
    logic clk;
    logic rst_n;

    output_port_arbiter_if #(.NREQ(5), .CW(3)) bus ();

    output_port_arbiter #(.NREQ(5), .CREDITS(4), .CW(3)) dut (
        .clk  (clk),
        .rst  (rst_n),
        .port (bus)
    );

    typedef struct {
        logic [4:0] grant;
        logic       fire;
        logic [2:0] credits;
        logic       busy;
        logic       cr_err;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input string fld,
                                input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req_v);
        end
    endfunction

    // Monitor: pops one expectation per cycle in which one was queued.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.name, "grant",   32'(bus.grant),   32'(e.grant));
            chk(e.name, "fire",    32'(bus.fire),    32'(e.fire));
            chk(e.name, "credits", 32'(bus.credits), 32'(e.credits));
            chk(e.name, "busy",    32'(bus.busy),    32'(e.busy));
            chk(e.name, "cr_err",  32'(bus.cr_err),  32'(e.cr_err));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic cyc(input logic [4:0] r, input logic [4:0] t, input logic cr,
                       input logic [4:0] eg, input logic ef, input logic [2:0] ec,
                       input logic eb, input logic ee, input string nm);
        exp_t e;
        bus.req        = r;
        bus.tail       = t;
        bus.credit_ret = cr;
        e.grant   = eg;
        e.fire    = ef;
        e.credits = ec;
        e.busy    = eb;
        e.cr_err  = ee;
        e.name    = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        bus.req        = '0;
        bus.tail       = '0;
        bus.credit_ret = 1'b0;
        @(posedge clk);
        #1;
        cyc(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0, "reset");
        rst_n = 1'b1;

        // Scenario A: owner 1 three flits, round-robin to input 4, credit overflow.
        cyc(5'b10010, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0, "a_idle");
        cyc(5'b10010, 5'b00000, 1'b0, 5'b00010, 1'b1, 3'd4, 1'b1, 1'b0, "a_f1");
        cyc(5'b10010, 5'b00000, 1'b0, 5'b00010, 1'b1, 3'd3, 1'b1, 1'b0, "a_f2");
        cyc(5'b10010, 5'b00010, 1'b0, 5'b00010, 1'b1, 3'd2, 1'b1, 1'b0, "a_f3_tail");
        cyc(5'b10010, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd1, 1'b0, 1'b0, "a_gap");
        cyc(5'b10000, 5'b10000, 1'b1, 5'b10000, 1'b1, 3'd1, 1'b1, 1'b0, "a_rr4_fire_ret");
        cyc(5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd1, 1'b0, 1'b0, "a_ret1");
        cyc(5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd2, 1'b0, 1'b0, "a_ret2");
        cyc(5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd3, 1'b0, 1'b0, "a_ret3");
        cyc(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0, "a_full");
        cyc(5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0, "a_overflow");
        cyc(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b1, "a_err_set");
        cyc(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b1, "a_err_sticky");

        rst_n = 1'b0;
        cyc(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0, "b_reset");
        rst_n = 1'b1;

        // Scenario B: six-flit packet against four credits.
        cyc(5'b00001, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0, "b_idle");
        cyc(5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b1, 3'd4, 1'b1, 1'b0, "b_f1");
        cyc(5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b1, 3'd3, 1'b1, 1'b0, "b_f2");
        cyc(5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b1, 3'd2, 1'b1, 1'b0, "b_f3");
        cyc(5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b1, 3'd1, 1'b1, 1'b0, "b_f4");
        cyc(5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b0, 3'd0, 1'b1, 1'b0, "b_stall_tail");
        cyc(5'b00001, 5'b00000, 1'b1, 5'b00001, 1'b0, 3'd0, 1'b1, 1'b0, "b_stall_ret");
        cyc(5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b1, 3'd1, 1'b1, 1'b0, "b_f5");
        cyc(5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b0, 3'd0, 1'b1, 1'b0, "b_stall2");
        cyc(5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b1, 3'd1, 1'b1, 1'b0, "b_f6_tail");
        cyc(5'b00100, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, "b_idle_zero_cred");
        cyc(5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b0, 3'd0, 1'b1, 1'b0, "b_lock_zero_cred");
        cyc(5'b00100, 5'b00100, 1'b0, 5'b00100, 1'b1, 3'd1, 1'b1, 1'b0, "b_one_flit");
        cyc(5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, "b_ret_a");
        cyc(5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd1, 1'b0, 1'b0, "b_ret_b");

        // Owner 3 with a mid-packet gap while input 0 waits.
        cyc(5'b01001, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd2, 1'b0, 1'b0, "c_idle");
        cyc(5'b01001, 5'b00000, 1'b1, 5'b01000, 1'b1, 3'd2, 1'b1, 1'b0, "c_fire_ret");
        cyc(5'b00001, 5'b00001, 1'b0, 5'b01000, 1'b0, 3'd2, 1'b1, 1'b0, "c_gap1");
        cyc(5'b00001, 5'b00000, 1'b0, 5'b01000, 1'b0, 3'd2, 1'b1, 1'b0, "c_gap2");
        cyc(5'b01001, 5'b00000, 1'b0, 5'b01000, 1'b1, 3'd2, 1'b1, 1'b0, "c_resume");
        cyc(5'b01001, 5'b01000, 1'b1, 5'b01000, 1'b1, 3'd1, 1'b1, 1'b0, "c_tail");
        cyc(5'b00001, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd1, 1'b0, 1'b0, "c_gap_idle");
        cyc(5'b00001, 5'b00000, 1'b1, 5'b00001, 1'b1, 3'd1, 1'b1, 1'b0, "c_grant0");

        // Reset mid-packet with one credit left.
        rst_n = 1'b0;
        cyc(5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0, "d_rst_mid");
        rst_n = 1'b1;
        cyc(5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0, "d_idle");
        cyc(5'b11111, 5'b00001, 1'b0, 5'b00001, 1'b1, 3'd4, 1'b1, 1'b0, "d_grant0");
        cyc(5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd3, 1'b0, 1'b0, "d_gap");
        cyc(5'b00000, 5'b00000, 1'b0, 5'b00010, 1'b0, 3'd3, 1'b1, 1'b0, "d_grant1_idle_req");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 5, number of requesting input ports (bit order N,S,E,W,L = 0..4).
REQ-002 SHALL have parameter CREDITS, default 4, downstream buffer depth in flits.
REQ-003 SHALL have parameter CW, default 3, credit counter width; CW SHALL hold the value CREDITS.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 req  input  NREQ  per-input request; a flit is presented on that input this cycle.
REQ-007 tail  input  NREQ  per-input flag; the presented flit is the packet's last flit.
REQ-008 credit_ret  input  1  downstream freed one buffer slot this cycle.
REQ-009 grant  output  NREQ  one-hot owner of the output port; all zero when unowned.
REQ-010 fire  output  1  one flit transfers from the owner to the output this cycle.
REQ-011 credits  output  CW  current downstream credit count.
REQ-012 busy  output  1  port is locked to an owner.
REQ-013 cr_err  output  1  sticky credit-overflow error flag.

Function
REQ-014 The FSM SHALL have two states: IDLE (grant=0, busy=0) and LOCKED (grant=onehot(owner), busy=1).
REQ-015 In IDLE with req!=0, SHALL select the first asserted req scanning from ptr+1 upward, modulo NREQ; owner is registered and the FSM enters LOCKED on the next edge.
REQ-016 Arbitration SHALL NOT depend on credits; a requester may lock the port while credits=0.
REQ-017 Latency: req rising in IDLE at cycle 0 -> grant asserted at cycle 1 -> earliest fire at cycle 1.
REQ-018 fire SHALL be combinational: LOCKED & req[owner] & (credits!=0).
REQ-019 In LOCKED, fire & tail[owner] SHALL return the FSM to IDLE and set ptr<=owner on that edge.
REQ-020 In LOCKED, req[owner]=0 SHALL hold the lock (mid-packet gap); grant SHALL stay unchanged.
REQ-021 In LOCKED, req and tail of non-owners SHALL be ignored.
REQ-022 One-flit packet (tail on first flit): grant lasts exactly one cycle when credits!=0.
REQ-023 After a tail, at least one IDLE cycle (grant=0) SHALL occur before the next grant.
REQ-024 Credit counter: fire alone -> credits-1; credit_ret alone -> credits+1; both together -> unchanged.
REQ-025 fire SHALL never be asserted with credits=0, so the counter SHALL never underflow.
REQ-026 credit_ret without fire at credits=CREDITS SHALL leave credits at CREDITS and set cr_err=1.
REQ-027 Once set, cr_err SHALL hold until reset.
REQ-028 tail on a non-fire cycle SHALL have no effect.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, grant=0, fire=0, busy=0, credits=CREDITS, ptr=NREQ-1 (input 0 highest priority) and cr_err=0.
REQ-030 Reset mid-packet SHALL abandon the packet; after release the port SHALL arbitrate afresh in IDLE.
REQ-031 The first rising clk edge after rst deasserts SHALL be a normal functional edge.

Verification
REQ-032 After reset, req=5'b10010 held -> cycle 1 grant=5'b00010, fire=1; credits 4 -> 3 per fire.
REQ-033 Owner 1 sends 3 flits, tail on the 3rd with req=5'b10010 still held -> one IDLE cycle, then grant=5'b10000 (round-robin from ptr=1).
REQ-034 Owner holds a 6-flit packet, no credit_ret -> 4 fires, credits=0, fire=0 with grant held; one credit_ret -> next cycle fire=1.
REQ-035 fire and credit_ret in the same cycle at credits=2 -> credits stays 2; credit_ret at credits=4 -> credits=4, cr_err=1.
REQ-036 Owner drops req for 2 cycles mid-packet while req[0]=1 -> grant unchanged, fire=0; the packet resumes and req[0] is granted only after the tail.
REQ-037 rst pulsed low mid-packet with credits=1 -> grant=0, busy=0, credits=4 immediately; req=5'b11111 -> grant=5'b00001.
